// File: rtl/hdr_pkg.sv
// hdr_pkg: shared constants and serve-state encoding for header_responder.
// Contents: header geometry, nonce word index, pad word, serve FSM states.
package hdr_pkg;

    localparam int HDR_BYTES  = 80;
    localparam int HDR_WORDS  = 20;
    localparam int NONCE_ADDR = 19;

    localparam logic [31:0] PAD_WORD = 32'h0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        HOLD  = 2'd2
    } srv_state_t;

endpackage

// File: rtl/header_responder_if.sv
// header_responder_if: word-fetch bus between hashing engine and responder.
// Ports: rq, addr (engine -> responder); data, rdy (responder -> engine).
interface header_responder_if;

    logic        rq;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        rdy;

    modport master (
        output rq,
        output addr,
        input  data,
        input  rdy
    );

    modport slave (
        input  rq,
        input  addr,
        output data,
        output rdy
    );

endinterface

// File: rtl/hdr_nonce_ctr.sv
// hdr_nonce_ctr: nonce register (header word 19) with byte-lane load,
// add-with-carry step and sticky wrap flag.
// Ports: clk, rst, ld_en/ld_lane/ld_byte, clr_wrap, inc, nonce, nonce_wrap.
module hdr_nonce_ctr #(
    parameter int unsigned NONCE_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_en,
    input  logic [1:0]  ld_lane,
    input  logic [7:0]  ld_byte,
    input  logic        clr_wrap,
    input  logic        inc,
    output logic [31:0] nonce,
    output logic        nonce_wrap
);

    logic [32:0] sum;

    assign sum = {1'b0, nonce} + {1'b0, 32'(NONCE_STEP)};

    always_ff @(posedge clk) begin
        if (rst) begin
            nonce      <= 32'h0;
            nonce_wrap <= 1'b0;
        end else begin
            // Lane 0 is the first byte of the word and lands in [31:24].
            if (ld_en) begin
                unique case (ld_lane)
                    2'd0: nonce[31:24] <= ld_byte;
                    2'd1: nonce[23:16] <= ld_byte;
                    2'd2: nonce[15:8]  <= ld_byte;
                    2'd3: nonce[7:0]   <= ld_byte;
                endcase
            end else if (inc) begin
                nonce <= sum[31:0];
            end

            if (clr_wrap) begin
                nonce_wrap <= 1'b0;
            end else if (inc && sum[32]) begin
                nonce_wrap <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/header_responder.sv
// header_responder: serves the 80-byte block header to the hash engine
// word by word, loads it byte-serially from the host, owns the nonce.
// Ports: clk, rst, ld_valid/ld_data/ld_ready, bus (rq/addr/data/rdy),
// nonce_inc, nonce, hdr_valid, nonce_wrap.
// Build option: HDR_NONCE_AUTO_EN auto-increments the nonce after
// every serve of word 19.
module header_responder
    import hdr_pkg::*;
#(
    parameter int unsigned NONCE_STEP = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_valid,
    input  logic [7:0]         ld_data,
    output logic               ld_ready,
    header_responder_if.slave  bus,
    input  logic               nonce_inc,
    output logic [31:0]        nonce,
    output logic               hdr_valid,
    output logic               nonce_wrap
);

    srv_state_t  state_q, state_d;
    logic [6:0]  cnt_q;
    logic        hdr_valid_q;
    logic [31:0] data_q;
    logic [31:0] rd_word;
    logic [31:0] buf_q [0:HDR_WORDS-2];
    logic        capture;
    logic        ld_acc;
    logic        first_byte;
    logic        last_byte;
    logic        in_buf;
    logic        auto_inc;
    logic        inc;

    assign ld_ready   = (state_q == IDLE);
    assign ld_acc     = ld_valid & ld_ready;
    assign first_byte = (cnt_q == 7'd0);
    assign last_byte  = (cnt_q == 7'(HDR_BYTES - 1));
    assign in_buf     = (cnt_q < 7'(4 * NONCE_ADDR));

    assign bus.rdy    = (state_q == SERVE);
    assign bus.data   = data_q;
    assign hdr_valid  = hdr_valid_q;

`ifdef HDR_NONCE_AUTO_EN
    logic [4:0] addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= 5'd0;
        end else if (capture) begin
            addr_q <= bus.addr;
        end
    end

    assign auto_inc = (state_q == SERVE) &&
                      (addr_q == 5'(NONCE_ADDR));
`else
    assign auto_inc = 1'b0;
`endif

    // An auto step and a host pulse in the same cycle merge into one.
    assign inc = (nonce_inc && hdr_valid_q && !ld_acc) || auto_inc;

    always_comb begin
        rd_word = PAD_WORD;
        if (bus.addr < 5'(NONCE_ADDR)) begin
            rd_word = buf_q[bus.addr];
        end else if (bus.addr == 5'(NONCE_ADDR)) begin
            rd_word = nonce;
        end
    end

    // A host byte wins over a new request in the same IDLE cycle.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.rq && hdr_valid_q && !ld_acc) begin
                    state_d = SERVE;
                    capture = 1'b1;
                end
            end
            SERVE: state_d = HOLD;
            HOLD: begin
                if (!bus.rq) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 7'd0;
            hdr_valid_q <= 1'b0;
            data_q      <= 32'h0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                data_q <= rd_word;
            end
            if (ld_acc) begin
                cnt_q <= last_byte ? 7'd0 : cnt_q + 7'd1;
                if (last_byte) begin
                    hdr_valid_q <= 1'b1;
                end else if (first_byte) begin
                    hdr_valid_q <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ld_acc && in_buf) begin
            unique case (cnt_q[1:0])
                2'd0: buf_q[cnt_q[6:2]][31:24] <= ld_data;
                2'd1: buf_q[cnt_q[6:2]][23:16] <= ld_data;
                2'd2: buf_q[cnt_q[6:2]][15:8]  <= ld_data;
                2'd3: buf_q[cnt_q[6:2]][7:0]   <= ld_data;
            endcase
        end
    end

    hdr_nonce_ctr #(
        .NONCE_STEP (NONCE_STEP)
    ) u_nonce (
        .clk        (clk),
        .rst        (rst),
        .ld_en      (ld_acc && !in_buf),
        .ld_lane    (cnt_q[1:0]),
        .ld_byte    (ld_data),
        .clr_wrap   (ld_acc && first_byte),
        .inc        (inc),
        .nonce      (nonce),
        .nonce_wrap (nonce_wrap)
    );

endmodule

// File: tb/tb_header_responder.sv
// tb_header_responder: randomized scoreboard bench for header_responder.
// Reference model holds the 80 header bytes and the nonce as plain values.
`timescale 1ns/1ps
module tb_header_responder;
    import hdr_pkg::*;

    localparam int unsigned STEP = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        nonce_inc;
    logic [31:0] nonce;
    logic        hdr_valid;
    logic        nonce_wrap;

    header_responder_if bus();

    header_responder #(
        .NONCE_STEP (STEP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .bus        (bus),
        .nonce_inc  (nonce_inc),
        .nonce      (nonce),
        .hdr_valid  (hdr_valid),
        .nonce_wrap (nonce_wrap)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          n_rdy  = 0;
    logic [31:0] exp_q [$];
    logic [7:0]  mb [HDR_BYTES];
    logic [31:0] m_nonce;
    logic        m_wrap;
    logic        m_valid;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int a);
        if (a < NONCE_ADDR)
            return {mb[4*a], mb[4*a+1], mb[4*a+2], mb[4*a+3]};
        if (a == NONCE_ADDR)
            return m_nonce;
        return 32'h0;
    endfunction

    function automatic void model_inc();
        logic [63:0] s;
        s = {32'h0, m_nonce} + 64'(STEP);
        if (s >= 64'h1_0000_0000) m_wrap = 1'b1;
        m_nonce = s[31:0];
    endfunction

    // Monitor: every rdy strobe must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && bus.rdy) begin
            n_rdy++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rdy: data %h, none outstanding",
                         bus.data);
            end else begin
                check("serve_data", bus.data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int stop_at, input int req_at,
                        input logic [4:0] req_addr);
        bit early = 1'b0;
        for (int k = 0; k < HDR_BYTES; k++) begin
            if (k == stop_at) begin
                ld_valid = 1'b0;
                return;
            end
            ld_valid = 1'b1;
            ld_data  = mb[k];
            if (k == req_at) begin
                bus.rq   = 1'b1;
                bus.addr = req_addr;
                exp_q.push_back(model_word(int'(req_addr)));
            end
            tick();
            if (k == 0) begin
                m_valid = 1'b0;
                m_wrap  = 1'b0;
            end
            if (bus.rdy) early = 1'b1;
            if (k == 40) begin
                check("hdr_valid_midload", 32'(hdr_valid), 32'(m_valid));
                check("wrap_clr_midload", 32'(nonce_wrap), 32'(m_wrap));
            end
        end
        ld_valid = 1'b0;
        m_nonce  = {mb[76], mb[77], mb[78], mb[79]};
        m_valid  = 1'b1;
        check("hdr_valid_done", 32'(hdr_valid), 32'(m_valid));
        check("nonce_loaded", nonce, m_nonce);
        if (req_at >= 0) check("no_early_rdy", 32'(early), 32'd0);
    endtask

    task automatic finish_serve(input logic [4:0] a, input bit inc_srv,
                                input int hold_extra);
        int cyc  = 0;
        bit got  = 1'b0;
        int rdy0 = n_rdy;
        bit auto19 = 1'b0;
`ifdef HDR_NONCE_AUTO_EN
        auto19 = (a == 5'(NONCE_ADDR));
`endif
        while (!got && cyc < 20) begin
            tick();
            cyc++;
            if (bus.rdy) got = 1'b1;
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL rdy_timeout: no rdy in %0d cycles, addr %0d",
                     cyc, a);
            exp_q.delete();
            bus.rq = 1'b0;
            repeat (3) tick();
            return;
        end
        check("rdy_latency", 32'(cyc), 32'd1);
        check("ld_ready_serve", 32'(ld_ready), 32'd0);
        if (inc_srv) nonce_inc = 1'b1;
        if (hold_extra == 0) bus.rq = 1'b0;
        tick();
        nonce_inc = 1'b0;
        if (inc_srv || auto19) model_inc();
        check("rdy_one_cycle", 32'(bus.rdy), 32'd0);
        repeat (hold_extra) tick();
        bus.rq = 1'b0;
        tick();
        check("rdy_count", 32'(n_rdy - rdy0), 32'd1);
        check("nonce_after", nonce, m_nonce);
        check("wrap_after", 32'(nonce_wrap), 32'(m_wrap));
        check("ld_ready_idle", 32'(ld_ready), 32'd1);
    endtask

    task automatic request(input logic [4:0] a, input bit inc_srv,
                           input int hold_extra);
        bus.rq   = 1'b1;
        bus.addr = a;
        exp_q.push_back(model_word(int'(a)));
        finish_serve(a, inc_srv, hold_extra);
    endtask

    task automatic pulse_inc();
        nonce_inc = 1'b1;
        tick();
        nonce_inc = 1'b0;
        if (m_valid) model_inc();
        check("nonce_inc", nonce, m_nonce);
        check("nonce_wrap", 32'(nonce_wrap), 32'(m_wrap));
    endtask

    task automatic check_reset_vals();
        check("rst_data", bus.data, 32'h0);
        check("rst_rdy", 32'(bus.rdy), 32'd0);
        check("rst_ld_ready", 32'(ld_ready), 32'd1);
        check("rst_hdr_valid", 32'(hdr_valid), 32'd0);
        check("rst_nonce", nonce, 32'h0);
        check("rst_wrap", 32'(nonce_wrap), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        ld_valid  = 1'b0;
        ld_data   = 8'h0;
        nonce_inc = 1'b0;
        bus.rq    = 1'b0;
        bus.addr  = 5'd0;
        m_nonce   = 32'h0;
        m_wrap    = 1'b0;
        m_valid   = 1'b0;
        repeat (3) tick();
        check_reset_vals();
        rst = 1'b0;
        tick();

        pulse_inc();

        for (int k = 0; k < HDR_BYTES; k++) mb[k] = 8'(k);
        load(-1, -1, 5'd0);
        request(5'd0, 1'b0, 0);
        check("nonce_plan", nonce, 32'h4C4D4E4F);
        request(5'd19, 1'b0, 0);
        request(5'd25, 1'b0, 5);

        load(-1, 10, 5'd5);
        finish_serve(5'd5, 1'b0, 0);

        for (int k = 0; k < HDR_BYTES; k++) mb[k] = 8'($urandom);
        load(-1, -1, 5'd0);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                pulse_inc();
            end else begin
                request(5'($urandom_range(0, 31)),
                        1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 2)));
            end
        end

        mb[76] = 8'hFF;
        mb[77] = 8'hFF;
        mb[78] = 8'hFF;
        mb[79] = 8'hFF;
        load(-1, -1, 5'd0);
        pulse_inc();
        check("wrap_nonce_zero", nonce, 32'h0);
        check("wrap_set", 32'(nonce_wrap), 32'd1);
        request(5'd19, 1'b0, 0);
        load(-1, -1, 5'd0);
        check("wrap_cleared", 32'(nonce_wrap), 32'd0);

        mb[76] = 8'h00;
        mb[77] = 8'h00;
        mb[78] = 8'h00;
        mb[79] = 8'h10;
        load(-1, -1, 5'd0);
        request(5'd19, 1'b0, 0);
`ifdef HDR_NONCE_AUTO_EN
        check("auto_nonce_11", nonce, 32'h11);
`endif
        request(5'd19, 1'b1, 0);
`ifdef HDR_NONCE_AUTO_EN
        check("auto_nonce_12", nonce, 32'h12);
`endif

        for (int k = 0; k < HDR_BYTES; k++) mb[k] = 8'($urandom);
        load(40, -1, 5'd0);
        rst = 1'b1;
        tick();
        exp_q.delete();
        m_nonce = 32'h0;
        m_wrap  = 1'b0;
        m_valid = 1'b0;
        check_reset_vals();
        rst = 1'b0;
        tick();
        load(-1, -1, 5'd0);
        for (int i = 0; i < 8; i++) begin
            request(5'($urandom_range(0, 20)), 1'b0, 0);
        end
        request(5'd18, 1'b0, 0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
